vending_controller: RTL

//  Parametrised multi-item vending FSM: NUM_ITEMS products, per-item price table and stock,

---
 rtl/vending_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/vending_controller.sv
// Multi-item vending controller with coin credit, change return, idle-timeout refund
// and admin stock/revenue modes. Feeds the BCD display path through display_value/display_tag.
module vending_controller #(
  parameter int                           NUM_ITEMS   = 4,
  parameter int                           ITEM_W      = 2,
  parameter int                           MONEY_W     = 8,
  parameter int                           QTY_W       = 16,
  parameter int                           REV_W       = 16,
  parameter logic [NUM_ITEMS*MONEY_W-1:0] PRICE_TABLE = {8'd50, 8'd45, 8'd25, 8'd35},
  parameter int                           INIT_QTY    = 10,
  parameter int                           MAX_CREDIT  = 200,
  parameter int                           TIMEOUT     = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ITEM_W-1:0]  item,
  input  logic               nickel,
  input  logic               dime,
  input  logic               quarter,
  input  logic               buy,
  input  logic               cancel,
  input  logic               admin,
  input  logic               info,
  output logic [2:0]         state,
  output logic [MONEY_W-1:0] credit,
  output logic [MONEY_W-1:0] change,
  output logic               vend,
  output logic [ITEM_W-1:0]  vend_item,
  output logic               coin_reject,
  output logic               sold_out,
  output logic [15:0]        display_value,
  output logic [1:0]         display_tag,
  output logic [REV_W-1:0]   revenue
);

  localparam int SUM_W = MONEY_W + 2;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_PRICE = 3'd0,
    S_QTY   = 3'd1,
    S_REV   = 3'd2,
    S_UPD   = 3'd3,
    S_BUY   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_DONE   = 2'd1,
    TAG_CHANGE = 2'd2
  } tag_t;

  state_t             state_q, state_d;
  tag_t               tag_q, tag_d;
  logic [MONEY_W-1:0] credit_q, credit_d;
  logic [MONEY_W-1:0] change_q, change_d;
  logic [REV_W-1:0]   revenue_q, revenue_d;
  logic [QTY_W-1:0]   stock_q [NUM_ITEMS];
  logic [QTY_W-1:0]   stock_d [NUM_ITEMS];
  logic [TO_W-1:0]    tcount_q, tcount_d;
  logic               vend_q, vend_d;
  logic [ITEM_W-1:0]  vend_item_q, vend_item_d;
  logic               coin_reject_q, coin_reject_d;
  logic               sold_out_q, sold_out_d;

  logic [ITEM_W:0]    item_ext;
  logic [ITEM_W-1:0]  sel;
  logic [MONEY_W-1:0] price;
  logic [SUM_W-1:0]   coin_val;
  logic [SUM_W-1:0]   credit_sum;
  logic               coin_any;
  logic               over_limit;
  logic [QTY_W:0]     stock_sum;
  logic [REV_W:0]     rev_sum;
  logic [MONEY_W-1:0] change_amt;
  state_t             mode;

  // Out-of-range selections fall back to item 0 so table lookups stay in bounds.
  always_comb begin
    item_ext   = {1'b0, item};
    sel        = (item_ext < (ITEM_W+1)'(NUM_ITEMS)) ? item : '0;
    price      = PRICE_TABLE[sel*MONEY_W +: MONEY_W];
    coin_val   = (nickel ? SUM_W'(5) : '0) + (dime ? SUM_W'(10) : '0) + (quarter ? SUM_W'(25) : '0);
    coin_any   = nickel | dime | quarter;
    credit_sum = SUM_W'(credit_q) + coin_val;
    over_limit = credit_sum > SUM_W'(MAX_CREDIT);
    stock_sum  = {1'b0, stock_q[sel]} + (QTY_W+1)'(coin_val);
    rev_sum    = {1'b0, revenue_q} + (REV_W+1)'(price);
    change_amt = credit_q - price;
    mode       = state_t'({1'b0, admin, info});
  end

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    credit_d      = credit_q;
    change_d      = change_q;
    revenue_d     = revenue_q;
    stock_d       = stock_q;
    tcount_d      = '0;
    vend_d        = 1'b0;
    vend_item_d   = vend_item_q;
    coin_reject_d = 1'b0;
    sold_out_d    = 1'b0;
    case (state_q)
      S_PRICE: begin
        if (coin_any && over_limit) begin
          coin_reject_d = 1'b1;
          state_d       = mode;
        end else if (coin_any) begin
          credit_d = credit_sum[MONEY_W-1:0];
          tag_d    = TAG_NONE;
          state_d  = S_BUY;
        end else begin
          state_d = mode;
          if (mode != S_PRICE) tag_d = TAG_NONE;
        end
      end
      S_QTY: begin
        state_d = mode;
      end
      S_REV: begin
        state_d = mode;
        if (cancel) revenue_d = '0;
      end
      S_UPD: begin
        state_d = mode;
        if (cancel) begin
          stock_d[sel] = '0;
        end else if (coin_any) begin
          stock_d[sel] = stock_sum[QTY_W] ? '1 : stock_sum[QTY_W-1:0];
        end
      end
      S_BUY: begin
        // Idle cycles count toward the auto-refund; any coin or buy restarts the count.
        tcount_d = tcount_q + 1'b1;
        if (cancel || (!buy && !coin_any && tcount_q == TO_W'(TIMEOUT - 1))) begin
          change_d = credit_q;
          credit_d = '0;
          tag_d    = TAG_CHANGE;
          state_d  = S_PRICE;
          tcount_d = '0;
        end else if (buy) begin
          tcount_d = '0;
          if (stock_q[sel] == '0) begin
            sold_out_d = 1'b1;
          end else if (credit_q >= price) begin
            vend_d       = 1'b1;
            vend_item_d  = sel;
            stock_d[sel] = stock_q[sel] - 1'b1;
            revenue_d    = rev_sum[REV_W] ? '1 : rev_sum[REV_W-1:0];
            change_d     = change_amt;
            credit_d     = '0;
            tag_d        = (change_amt == '0) ? TAG_DONE : TAG_CHANGE;
            state_d      = S_PRICE;
          end
        end else if (coin_any) begin
          tcount_d = '0;
          if (over_limit) coin_reject_d = 1'b1;
          else            credit_d      = credit_sum[MONEY_W-1:0];
        end
      end
      default: begin
        state_d = S_PRICE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_PRICE;
      tag_q         <= TAG_NONE;
      credit_q      <= '0;
      change_q      <= '0;
      revenue_q     <= '0;
      tcount_q      <= '0;
      vend_q        <= 1'b0;
      vend_item_q   <= '0;
      coin_reject_q <= 1'b0;
      sold_out_q    <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= QTY_W'(INIT_QTY);
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      credit_q      <= credit_d;
      change_q      <= change_d;
      revenue_q     <= revenue_d;
      tcount_q      <= tcount_d;
      vend_q        <= vend_d;
      vend_item_q   <= vend_item_d;
      coin_reject_q <= coin_reject_d;
      sold_out_q    <= sold_out_d;
      stock_q       <= stock_d;
    end
  end

  // After a sale or refund the PRICE display shows the change until the tag clears.
  always_comb begin
    display_value = '0;
    case (state_q)
      S_PRICE: display_value = (tag_q != TAG_NONE) ? 16'(change_q) : 16'(price);
      S_QTY:   display_value = 16'(stock_q[sel]);
      S_REV:   display_value = 16'(revenue_q);
      S_UPD:   display_value = 16'(stock_q[sel]);
      S_BUY:   display_value = 16'(credit_q);
      default: display_value = '0;
    endcase
  end

  assign state       = state_q;
  assign credit      = credit_q;
  assign change      = change_q;
  assign vend        = vend_q;
  assign vend_item   = vend_item_q;
  assign coin_reject = coin_reject_q;
  assign sold_out    = sold_out_q;
  assign display_tag = tag_q;
  assign revenue     = revenue_q;

endmodule
